// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and constants for the APB-to-memory bridge.
//             Provides the bridge FSM state type, default bus widths and
//             the wait-state counter sizing.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W      = 8;
    localparam int APB_DATA_W      = 8;
    localparam int MAX_WAIT_STATES = 7;

    // Counter must be able to hold the largest legal wait-state value.
    localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_mem_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_bridge_if
//  Purpose  : APB3 bus bundle between an APB master and the memory bridge.
//  Ports    : PSEL, PENABLE, PWRITE, PADDR, PWDATA  (master -> slave)
//             PRDATA, PREADY, PSLVERR               (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_mem_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface
`default_nettype wire

// File: rtl/apb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_wait_counter
//  Purpose  : Counts ACCESS cycles 0..WAIT_STATES and raises a registered
//             done flag during the cycle in which the count equals
//             WAIT_STATES. The flag holds until clr_i.
//  Ports    : clk, rst_n  - clock, async active-low reset
//             clr_i       - force count and flag to zero
//             en_i        - advance the count (saturates at WAIT_STATES)
//             done_o      - high while count == WAIT_STATES
//  Revision : 1.0 - initial release
// ============================================================================
module apb_wait_counter
    import apb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WAIT_STATES);

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en_i && (cnt_q != c_last)) begin
            cnt_q  <= cnt_q + 1'b1;
            // Flag is computed from the next count so it is registered
            // and coincides with the cycle where count == WAIT_STATES.
            done_q <= ((cnt_q + 1'b1) == c_last);
        end
    end

    assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/apb_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_bridge
//  Purpose  : APB3 slave that turns each transfer into exactly one
//             single-cycle memory read or write strobe, with programmable
//             wait states and an address-limit error response.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             bus (slave modport)   - APB3 bus
//             read_addr/write_addr  - latched transfer address
//             write_data            - latched write data
//             mem_write/mem_read    - one-cycle memory strobes
//             read_data             - memory read data (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_bridge
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    apb_mem_bridge_if.slave   bus,
    output logic [ADDR_W-1:0] read_addr,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] read_data
);

    apb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cap_q;
    logic              write_q;
    logic              err_q;
    logic              mem_write_q;
    logic              mem_read_q;
    logic              ready;

    logic              setup;
    logic              complete;
    logic              abort;
    logic              addr_err;

    // Widened compare keeps the check meaningful even when ADDR_LIMIT is
    // the all-ones address.
    assign addr_err = ({1'b0, bus.PADDR} > {1'b0, ADDR_LIMIT});

    assign setup    = (state_q == IDLE)   &&  bus.PSEL && !bus.PENABLE;
    assign complete = (state_q == ACCESS) &&  bus.PSEL &&  bus.PENABLE && ready;
    assign abort    = (state_q == ACCESS) && !bus.PSEL;

    apb_wait_counter #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state_q == IDLE) || complete || abort),
        .en_i   (state_q == ACCESS),
        .done_o (ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly the first ACCESS cycle.
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;

            // mem_read_q is high only during A0 of a legal read, so this
            // captures the memory data on the edge ending A0.
            if (mem_read_q) begin
                cap_q <= read_data;
            end

            case (state_q)
                IDLE: begin
                    if (setup) begin
                        addr_q      <= bus.PADDR;
                        wdata_q     <= bus.PWDATA;
                        write_q     <= bus.PWRITE;
                        err_q       <= addr_err;
                        mem_write_q <=  bus.PWRITE && !addr_err;
                        mem_read_q  <= !bus.PWRITE && !addr_err;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (complete || abort) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_addr   = addr_q;
    assign write_addr  = addr_q;
    assign write_data  = wdata_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;

    assign bus.PREADY  = ready;
    assign bus.PSLVERR = ready && err_q;
    assign bus.PRDATA  = (ready && !write_q && !err_q) ? cap_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mem_bridge
//  Purpose  : Directed self-checking bench for apb_mem_bridge. Three
//             instances: default, ADDR_LIMIT=8'h7F, WAIT_STATES=4, each with
//             its own 256x8 combinational-read memory model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_bridge;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_init;

    always #5 clk = ~clk;

    // Per-instance APB drive and observation
    logic       psel   [3];
    logic       pen    [3];
    logic       pwr    [3];
    logic [7:0] paddr  [3];
    logic [7:0] pwdata [3];
    logic [7:0] prdata [3];
    logic       pready [3];
    logic       pslverr[3];
    logic [7:0] raddr  [3];
    logic [7:0] waddr  [3];
    logic [7:0] wdata  [3];
    logic       mwr    [3];
    logic       mrd    [3];
    logic [7:0] rdata  [3];

    int checks   = 0;
    int failures = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int         c_ws    = (k == 2) ? 4 : 1;
        localparam logic [7:0] c_limit = (k == 1) ? 8'h7F : 8'hFF;

        apb_mem_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

        logic [7:0] mem [256];

        assign bus.PSEL    = psel[k];
        assign bus.PENABLE = pen[k];
        assign bus.PWRITE  = pwr[k];
        assign bus.PADDR   = paddr[k];
        assign bus.PWDATA  = pwdata[k];
        assign prdata[k]   = bus.PRDATA;
        assign pready[k]   = bus.PREADY;
        assign pslverr[k]  = bus.PSLVERR;
        assign rdata[k]    = mem[raddr[k]];

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) begin
                    mem[i] <= 8'h00;
                end
                if (k == 1) mem[8'h80] <= 8'hC3;
                if (k == 2) mem[8'h10] <= 8'hA5;
            end else if (mwr[k]) begin
                mem[waddr[k]] <= wdata[k];
            end
        end

        apb_mem_bridge #(
            .ADDR_W      (8),
            .DATA_W      (8),
            .WAIT_STATES (c_ws),
            .ADDR_LIMIT  (c_limit)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus        (bus),
            .read_addr  (raddr[k]),
            .write_addr (waddr[k]),
            .write_data (wdata[k]),
            .mem_write  (mwr[k]),
            .mem_read   (mrd[k]),
            .read_data  (rdata[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SETUP cycle then land in A0 with PENABLE raised
    task automatic do_setup(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        psel[k]   = 1'b1;
        pen[k]    = 1'b0;
        pwr[k]    = wr;
        paddr[k]  = a;
        pwdata[k] = d;
        step();
        pen[k]    = 1'b1;
    endtask

    task automatic end_xfer(input int k);
        step();
        psel[k] = 1'b0;
        pen[k]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        mem_init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            psel[k] = 0; pen[k] = 0; pwr[k] = 0; paddr[k] = '0; pwdata[k] = '0;
        end
        repeat (2) step();

        // Reset state
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_pready%0d", k),  pready[k],  1'b0);
            chk($sformatf("rst_pslverr%0d", k), pslverr[k], 1'b0);
            chk($sformatf("rst_prdata%0d", k),  prdata[k],  8'h00);
            chk($sformatf("rst_strobes%0d", k), {mwr[k], mrd[k]}, 2'b00);
            chk($sformatf("rst_addr%0d", k),    {raddr[k], waddr[k], wdata[k]}, 24'h0);
        end
        mem_init = 1'b0;
        rst_n    = 1'b1;
        step();

        // Write A5 @ 10 on default instance
        do_setup(0, 1'b1, 8'h10, 8'hA5);
        chk("wr_a0_mwr",    mwr[0], 1'b1);
        chk("wr_a0_mrd",    mrd[0], 1'b0);
        chk("wr_a0_waddr",  waddr[0], 8'h10);
        chk("wr_a0_wdata",  wdata[0], 8'hA5);
        chk("wr_a0_pready", pready[0], 1'b0);
        paddr[0] = 8'h33; pwdata[0] = 8'h00; pwr[0] = 1'b0;   // ignored mid-ACCESS
        step();
        chk("wr_a1_mwr",     mwr[0], 1'b0);
        chk("wr_a1_pready",  pready[0], 1'b1);
        chk("wr_a1_pslverr", pslverr[0], 1'b0);
        chk("wr_a1_waddr",   waddr[0], 8'h10);
        chk("wr_a1_wdata",   wdata[0], 8'hA5);
        chk("wr_a1_prdata",  prdata[0], 8'h00);
        end_xfer(0);
        chk("wr_idle_pready", pready[0], 1'b0);
        chk("wr_mem10",       g_dut[0].mem[8'h10], 8'hA5);

        // Read back @ 10
        do_setup(0, 1'b0, 8'h10, 8'h00);
        chk("rd_a0_mrd",    mrd[0], 1'b1);
        chk("rd_a0_mwr",    mwr[0], 1'b0);
        chk("rd_a0_raddr",  raddr[0], 8'h10);
        chk("rd_a0_prdata", prdata[0], 8'h00);
        step();
        chk("rd_a1_mrd",     mrd[0], 1'b0);
        chk("rd_a1_pready",  pready[0], 1'b1);
        chk("rd_a1_prdata",  prdata[0], 8'hA5);
        chk("rd_a1_pslverr", pslverr[0], 1'b0);
        end_xfer(0);

        // Back-to-back: write 01@00, write FF@FF, read @00
        do_setup(0, 1'b1, 8'h00, 8'h01);
        chk("b2b1_a0_mwr", mwr[0], 1'b1);
        step();
        chk("b2b1_a1", {pready[0], mwr[0]}, 2'b10);
        step();
        do_setup(0, 1'b1, 8'hFF, 8'hFF);
        chk("b2b2_a0_mwr",   mwr[0], 1'b1);
        chk("b2b2_a0_waddr", waddr[0], 8'hFF);
        step();
        chk("b2b2_a1", {pready[0], pslverr[0], mwr[0]}, 3'b100);
        step();
        do_setup(0, 1'b0, 8'h00, 8'h00);
        chk("b2b3_a0", {mrd[0], mwr[0], raddr[0]}, {2'b10, 8'h00});
        step();
        chk("b2b3_a1", {pready[0], mrd[0], prdata[0]}, {2'b10, 8'h01});
        end_xfer(0);
        chk("b2b_memFF", g_dut[0].mem[8'hFF], 8'hFF);
        chk("b2b_mem00", g_dut[0].mem[8'h00], 8'h01);

        // Address-limit errors on ADDR_LIMIT=7F instance
        do_setup(1, 1'b1, 8'h80, 8'h55);
        chk("errw_a0", {mwr[1], mrd[1], pready[1]}, 3'b000);
        step();
        chk("errw_a1", {pready[1], pslverr[1], mwr[1]}, 3'b110);
        end_xfer(1);
        chk("errw_mem80", g_dut[1].mem[8'h80], 8'hC3);
        do_setup(1, 1'b0, 8'h80, 8'h00);
        chk("errr_a0", {mrd[1], mwr[1]}, 2'b00);
        step();
        chk("errr_a1", {pready[1], pslverr[1], prdata[1]}, {2'b11, 8'h00});
        end_xfer(1);
        do_setup(1, 1'b1, 8'h7F, 8'h66);
        chk("lim_a0_mwr", mwr[1], 1'b1);
        step();
        chk("lim_a1", {pready[1], pslverr[1]}, 2'b10);
        end_xfer(1);
        chk("lim_mem7F", g_dut[1].mem[8'h7F], 8'h66);

        // WAIT_STATES=4 read
        do_setup(2, 1'b0, 8'h10, 8'h00);
        chk("ws_a0", {mrd[2], pready[2]}, 2'b10);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("ws_a%0d_pready", i), pready[2], 1'b0);
        end
        step();
        chk("ws_a4", {pready[2], pslverr[2], prdata[2]}, {2'b10, 8'hA5});
        end_xfer(2);

        // Repeat read, PSEL dropped in A2 -> abort
        do_setup(2, 1'b0, 8'h10, 8'h00);
        chk("ab_a0_mrd", mrd[2], 1'b1);
        step();
        step();
        psel[2] = 1'b0;
        pen[2]  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ab_idle%0d", i), {pready[2], mrd[2], mwr[2]}, 3'b000);
        end
        do_setup(2, 1'b0, 8'h10, 8'h00);
        chk("ab_resetup_mrd", mrd[2], 1'b1);
        repeat (4) step();
        chk("ab_resetup_a4", {pready[2], prdata[2]}, {1'b1, 8'hA5});
        end_xfer(2);

        // Reset pulsed in A0 of a write
        do_setup(0, 1'b1, 8'h20, 8'h77);
        chk("rst_a0_mwr", mwr[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {mwr[0], mrd[0], pready[0], pslverr[0]}, 4'b0000);
        chk("rst_async_bus", {waddr[0], wdata[0], prdata[0]}, 24'h0);
        step();
        rst_n = 1'b1;       // PSEL/PENABLE still high: no SETUP seen
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_rel%0d", i), {pready[0], mwr[0], mrd[0]}, 3'b000);
        end
        psel[0] = 1'b0;
        pen[0]  = 1'b0;
        step();
        chk("rst_mem20", g_dut[0].mem[8'h20], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_mem_bridge.md
Name: apb_mem_bridge

Overview:
APB3 slave front-end that sits directly upstream of the 256x8 data memory and converts APB transfers into single-cycle memory strobes. It latches address, data and direction in the APB SETUP phase and issues exactly one mem_write or mem_read pulse per transfer. It captures read data and returns it on PRDATA, with programmable wait states and an address-limit error response.

Parameters:
ADDR_W, 8, address width (PADDR, read_addr, write_addr)
DATA_W, 8, data width (PWDATA, PRDATA, write_data, read_data)
WAIT_STATES, 1, ACCESS cycles before PREADY; legal range 1..7
ADDR_LIMIT, 8'hFF, highest legal address; above it the transfer errors with no memory access

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable (ACCESS phase)
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  APB address
PWDATA  in  DATA_W  APB write data
PRDATA  out  DATA_W  APB read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response; valid only with PREADY
read_addr  out  ADDR_W  memory read address
write_addr  out  ADDR_W  memory write address
write_data  out  DATA_W  memory write data
mem_write  out  1  memory write strobe, one cycle
mem_read  out  1  memory read strobe, one cycle
read_data  in  DATA_W  memory read data

Behaviour:
- Reset (async assert, sync release): state=IDLE, wait counter=0, all outputs 0, capture register=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 at a rising edge, latch PADDR, PWDATA and PWRITE.
  - Set err_q = (PADDR > ADDR_LIMIT) and go to ACCESS with cnt=0.
  - PENABLE=1 while in IDLE (no prior SETUP) is ignored: no strobe, PREADY=0.
- ACCESS cycles are numbered A0, A1, and so on.
- A0: if err_q=0, assert mem_write (latched PWRITE=1) or mem_read (PWRITE=0) for exactly A0.
- read_addr and write_addr both carry the latched address from A0 until the next SETUP. write_data carries the latched PWDATA.
- Read capture: read_data is sampled into the capture register on the edge ending A0.
- PREADY=1 during cycle A_WAIT_STATES only (registered; cnt counts 0..WAIT_STATES). PSLVERR=err_q in the same cycle, else 0.
- PRDATA = capture register when PREADY=1, PWRITE latched 0 and err_q=0; otherwise 0.
- Completion is the edge with PSEL & PENABLE & PREADY; the FSM returns to IDLE.
- A new SETUP is accepted in the cycle immediately after completion (back-to-back transfers, one idle-free SETUP cycle each).
- PSEL deasserts during ACCESS (protocol violation): abort to IDLE on that edge, with no PREADY and no further strobes. A strobe already issued in A0 is not retracted.
- PADDR and PWDATA changing during ACCESS have no effect (latched values are used).
- Error transfer: no mem_write or mem_read, memory untouched, PREADY timing unchanged.
- Reset asserted mid-transfer: outputs clear immediately. No strobe is issued after reset release until a fresh SETUP.
- Minimum transfer length is SETUP + (WAIT_STATES+1) ACCESS cycles; default 3 clocks.

Decomposition:
- Shared package apb_pkg: state enum (IDLE, ACCESS), APB_ADDR_W=8, APB_DATA_W=8, MAX_WAIT_STATES=7 constant.
- One sub-module apb_wait_counter: load/clear, count up to WAIT_STATES, raise done flag. Used for PREADY generation.
- All other logic in the top module.

Test Plan:
- Write 8'hA5 to addr 8'h10 with default WAIT_STATES=1 -> mem_write high exactly in A0, write_addr=8'h10, write_data=8'hA5; PREADY high in A1, PSLVERR=0; transfer takes 3 clocks.
- Read addr 8'h10 after that write -> mem_read high only in A0, read_addr=8'h10; PREADY in A1 with PRDATA=8'hA5, PSLVERR=0.
- Back-to-back transfers write 8'h01@8'h00, write 8'hFF@8'hFF, read @8'h00 -> three strobes, one per transfer, no idle cycles; final PRDATA=8'h01.
- ADDR_LIMIT=8'h7F, write 8'h55 to 8'h80 -> no mem_write, PREADY+PSLVERR=1 in A1; a following read of 8'h80 returns PRDATA=0 with PSLVERR=1.
- WAIT_STATES=4, read 8'h10 -> PREADY low in A0..A3, high in A4 with PRDATA=8'hA5; PSEL dropped in A2 on a repeat read -> no PREADY, FSM back to IDLE.
- rst_n pulsed low during A0 of a write -> all outputs 0 asynchronously, no strobe after release; PENABLE=1 without SETUP after reset -> PREADY stays 0.
